// File: rtl/crt_cpu_bus_if.sv
// Signal bundle between crt_cpu_bus, the MCU strobes and the video-memory arbiter.
// ctrl/aux keep at least one bit so CTRL_W=0 or AUX_N=0 builds stay legal.
interface crt_cpu_bus_if #(
    parameter int ADDR_W = 20,
    parameter int CTRL_W = 2,
    parameter int AUX_N  = 1
);
    localparam int CTRL_PW = (CTRL_W > 0) ? CTRL_W : 1;
    localparam int AUX_PW  = (AUX_N > 0) ? 8 * AUX_N : 8;

    logic                as;
    logic                ds;
    logic                wr;
    logic [7:0]          dbi;
    logic [7:0]          dbo;
    logic [ADDR_W-1:0]   da;
    logic [CTRL_PW-1:0]  ctrl;
    logic [AUX_PW-1:0]   aux;
    logic                mem_re;
    logic                mem_we;

    modport master (
        output as, ds, wr, dbi,
        input  dbo, da, ctrl, aux, mem_re, mem_we
    );

    modport slave (
        input  as, ds, wr, dbi,
        output dbo, da, ctrl, aux, mem_re, mem_we
    );
endinterface

// File: rtl/crt_cpu_bus.sv
// CPU bus slave for the CRT controller: byte-loaded pointer/ctrl, aux registers, memory requests.
// Optional macro CRT_BUS_CARRY_EN: the ds-fall increment carries across all ADDR_W address bits.
module crt_cpu_bus #(
    parameter int ADDR_W = 20,
    parameter int CTRL_W = 2,
    parameter int INC_W  = 8,
    parameter int AUX_N  = 1,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    inout  wire  [7:0]   db,
    crt_cpu_bus_if.slave bus
);
    localparam int PW      = ADDR_W + CTRL_W;
    localparam int NB      = (PW + 7) / 8;
    localparam int NSEL    = NB + AUX_N;
    localparam int SW      = (NSEL > 1) ? $clog2(NSEL) : 1;
    localparam int AUX_PW  = (AUX_N > 0) ? 8 * AUX_N : 8;
    localparam logic [SW-1:0]     SEL_LAST = SW'(NSEL - 1);
    localparam logic [NB*8-1:0]   P_MASK   = {(NB*8){1'b1}} >> (NB*8 - PW);
`ifdef CRT_BUS_CARRY_EN
    localparam logic [ADDR_W-1:0] INC_MASK = {ADDR_W{1'b1}};
`else
    localparam logic [ADDR_W-1:0] INC_MASK = {ADDR_W{1'b1}} >> (ADDR_W - INC_W);
`endif

    logic              as_s0, as_s1, ds_s0, ds_s1, wr_s0;
    logic              started, as_arm, ds_arm;
    logic [NB*8-1:0]   p_q, p_next;
    logic [AUX_PW-1:0] aux_q, aux_next;
    logic [SW-1:0]     sel_q, sel_next;
    logic [7:0]        rd_hold, rb_byte;
    logic [ADDR_W-1:0] addr_inc;
    logic              as_rise, as_fall, ds_rise, ds_fall, as_load;
    logic              mem_we_i, mem_re_i, db_oe;
    logic [RD_LAT:0]   re_vec;

    // A pin held high through reset never strobes until it has been seen low again.
    assign as_rise  = as_s0 & ~as_s1 & as_arm;
    assign as_fall  = as_s1 & ~as_s0 & as_arm;
    assign ds_rise  = ds_s0 & ~ds_s1 & ds_arm;
    assign ds_fall  = ds_s1 & ~ds_s0 & ds_arm;
    assign mem_we_i = ds_rise & wr_s0;
    assign mem_re_i = ds_rise & ~wr_s0;
    assign as_load  = as_rise & ~ds_rise & wr_s0;
    assign addr_inc = (p_q[ADDR_W-1:0] & ~INC_MASK) | ((p_q[ADDR_W-1:0] + ADDR_W'(1)) & INC_MASK);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        p_next   = p_q;
        aux_next = aux_q;
        sel_next = sel_q;
        if (ds_fall) p_next[ADDR_W-1:0] = addr_inc;
        if (ds_rise) begin
            sel_next = '0;
        end else begin
            if (as_load) begin
                for (int i = 0; i < NB; i++)
                    if (sel_q == SW'(i)) p_next[8*i +: 8] = db & P_MASK[8*i +: 8];
                for (int j = 0; j < AUX_N; j++)
                    if (sel_q == SW'(NB + j)) aux_next[8*j +: 8] = db;
            end
            if (as_fall) sel_next = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        end
    end

    always_comb begin
        rb_byte = '0;
        for (int i = 0; i < NB; i++)
            if (sel_q == SW'(i)) rb_byte = p_q[8*i +: 8];
        for (int j = 0; j < AUX_N; j++)
            if (sel_q == SW'(NB + j)) rb_byte = aux_q[8*j +: 8];
    end

    // wr is sampled on the same edge as s0 so it is valid in every strobe cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            as_s0   <= 1'b0;
            as_s1   <= 1'b0;
            ds_s0   <= 1'b0;
            ds_s1   <= 1'b0;
            wr_s0   <= 1'b0;
            started <= 1'b0;
            as_arm  <= 1'b0;
            ds_arm  <= 1'b0;
            p_q     <= '0;
            aux_q   <= '0;
            sel_q   <= '0;
            rd_hold <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            as_s0   <= bus.as;
            as_s1   <= as_s0;
            ds_s0   <= bus.ds;
            ds_s1   <= ds_s0;
            wr_s0   <= bus.wr;
            started <= 1'b1;
            as_arm  <= as_arm | (started & ~as_s0);
            ds_arm  <= ds_arm | (started & ~ds_s0);
            p_q     <= p_next;
            aux_q   <= aux_next;
            sel_q   <= sel_next;
            if (re_vec[RD_LAT]) rd_hold <= bus.dbi;
        end
    end

    // re_vec[k] is high k clocks after the mem_re cycle.
    assign re_vec[0] = mem_re_i;
    if (RD_LAT > 0) begin : g_pipe
        logic [RD_LAT:1] re_sr;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) re_sr <= '0;
            else        re_sr <= re_vec[RD_LAT-1:0];
        end
        assign re_vec[RD_LAT:1] = re_sr;
    end

    assign db_oe = (bus.as | bus.ds) & ~bus.wr;
    assign db    = db_oe ? (bus.ds ? rd_hold : rb_byte) : 8'bz;

    assign bus.dbo    = db;
    assign bus.da     = p_q[ADDR_W-1:0];
    assign bus.aux    = aux_q;
    assign bus.mem_we = mem_we_i;
    assign bus.mem_re = mem_re_i;

    if (CTRL_W > 0) begin : g_ctrl
        assign bus.ctrl = p_q[PW-1 -: CTRL_W];
    end else begin : g_no_ctrl
        assign bus.ctrl = 1'b0;
    end
endmodule

// File: tb/tb_crt_cpu_bus.sv
// Directed bench for crt_cpu_bus: table of MCU accesses plus hand-written corner sequences.
// Build with CRT_BUS_CARRY_EN defined to expect the carrying address increment.
module tb_crt_cpu_bus;
    localparam int ADDR_W = 20;
    localparam int CTRL_W = 2;
    localparam int INC_W  = 8;
    localparam int AUX_N  = 1;
    localparam int RD_LAT = 2;
    localparam int NV     = 20;
`ifdef CRT_BUS_CARRY_EN
    localparam logic [19:0] HI = 20'h00100;
`else
    localparam logic [19:0] HI = 20'h00000;
`endif

    logic       clk = 1'b0;
    logic       reset;
    wire  [7:0] db;
    logic [7:0] db_drv;
    logic       db_en;
    assign db = db_en ? db_drv : 8'bz;

    crt_cpu_bus_if #(.ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .AUX_N(AUX_N)) bus ();

    crt_cpu_bus #(
        .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .INC_W(INC_W), .AUX_N(AUX_N), .RD_LAT(RD_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .db   (db),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    int          re_cnt = 0;
    logic [19:0] we_addr = '0;
    logic [7:0]  we_data = '0;
    logic [7:0]  mem_data = '0;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            we_cnt++;
            we_addr = bus.da;
            we_data = bus.dbo;
        end
        if (bus.mem_re) re_cnt++;
    end

    // Memory returns mem_data only during the cycle two clocks after mem_re.
    initial begin
        bus.dbi = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.mem_re) begin
                @(posedge clk);
                @(posedge clk);
                #1 bus.dbi = mem_data;
                @(posedge clk);
                #1 bus.dbi = 8'h00;
            end
        end
    end

    typedef struct {
        logic        is_ds;
        logic        wr;
        logic [7:0]  wdata;
        logic [7:0]  mem;
        logic [19:0] exp_da;
        logic [1:0]  exp_ctrl;
        logic [7:0]  exp_aux;
        logic [7:0]  exp_rd;
        logic [19:0] exp_we;
    } vec_t;

    vec_t vt [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic access(input logic is_ds, input logic w, input logic [7:0] d,
                          output logic [7:0] rd);
        @(posedge clk);
        #2;
        bus.wr = w;
        db_drv = d;
        db_en  = w;
        if (is_ds) bus.ds = 1'b1;
        else       bus.as = 1'b1;
        repeat (6) @(posedge clk);
        #2 rd = db;
        bus.as = 1'b0;
        bus.ds = 1'b0;
        repeat (4) @(posedge clk);
        #2 db_en = 1'b0;
    endtask

    logic [7:0] rd;
    int         we0, re0;

    initial begin
        //          ds   wr   wdata  mem    da             ctrl   aux    rd     we addr
        vt[0]  = '{1'b0, 1'b1, 8'h34, 8'h00, 20'h00034,     2'b00, 8'h00, 8'h00, 20'h0};
        vt[1]  = '{1'b0, 1'b1, 8'h12, 8'h00, 20'h01234,     2'b00, 8'h00, 8'h00, 20'h0};
        vt[2]  = '{1'b0, 1'b1, 8'hC5, 8'h00, 20'h51234,     2'b00, 8'h00, 8'h00, 20'h0};
        vt[3]  = '{1'b0, 1'b1, 8'h07, 8'h00, 20'h51234,     2'b00, 8'h07, 8'h00, 20'h0};
        vt[4]  = '{1'b0, 1'b1, 8'h78, 8'h00, 20'h51278,     2'b00, 8'h07, 8'h00, 20'h0};
        vt[5]  = '{1'b0, 1'b1, 8'h56, 8'h00, 20'h55678,     2'b00, 8'h07, 8'h00, 20'h0};
        vt[6]  = '{1'b0, 1'b1, 8'hF5, 8'h00, 20'h55678,     2'b11, 8'h07, 8'h00, 20'h0};
        vt[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 20'h55678,     2'b11, 8'h07, 8'h07, 20'h0};
        vt[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 20'h55678,     2'b11, 8'h07, 8'h78, 20'h0};
        vt[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 20'h55678,     2'b11, 8'h07, 8'h56, 20'h0};
        vt[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 20'h55678,     2'b11, 8'h07, 8'h35, 20'h0};
        vt[11] = '{1'b0, 1'b1, 8'h5A, 8'h00, 20'h55678,     2'b11, 8'h5A, 8'h00, 20'h0};
        vt[12] = '{1'b0, 1'b1, 8'hFE, 8'h00, 20'h556FE,     2'b11, 8'h5A, 8'h00, 20'h0};
        vt[13] = '{1'b0, 1'b1, 8'h00, 8'h00, 20'h500FE,     2'b11, 8'h5A, 8'h00, 20'h0};
        vt[14] = '{1'b0, 1'b1, 8'h00, 8'h00, 20'h000FE,     2'b00, 8'h5A, 8'h00, 20'h0};
        vt[15] = '{1'b1, 1'b1, 8'h11, 8'h00, 20'h000FF,     2'b00, 8'h5A, 8'h00, 20'h000FE};
        vt[16] = '{1'b1, 1'b1, 8'h22, 8'h00, 20'h00000|HI,  2'b00, 8'h5A, 8'h00, 20'h000FF};
        vt[17] = '{1'b1, 1'b1, 8'h33, 8'h00, 20'h00001|HI,  2'b00, 8'h5A, 8'h00, 20'h00000|HI};
        vt[18] = '{1'b1, 1'b0, 8'h00, 8'hA5, 20'h00002|HI,  2'b00, 8'h5A, 8'hA5, 20'h0};
        vt[19] = '{1'b1, 1'b0, 8'h00, 8'h3C, 20'h00003|HI,  2'b00, 8'h5A, 8'h3C, 20'h0};

        bus.as = 1'b0;
        bus.ds = 1'b0;
        bus.wr = 1'b1;
        db_drv = 8'hAA;
        db_en  = 1'b1;
        reset  = 1'b0;

        // Strobes toggle while reset is held.
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #2 bus.as = k[0];
            bus.ds = ~k[0];
        end
        #2 bus.as = 1'b0;
        bus.ds = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst da", bus.da, 20'h0);
        check("rst ctrl", bus.ctrl, 2'b00);
        check("rst aux", bus.aux, 8'h00);
        check("rst pulses", we_cnt + re_cnt, 0);
        reset = 1'b1;
        db_en = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            we0 = we_cnt;
            re0 = re_cnt;
            mem_data = vt[i].mem;
            access(vt[i].is_ds, vt[i].wr, vt[i].wdata, rd);
            check($sformatf("v%0d da", i), bus.da, vt[i].exp_da);
            check($sformatf("v%0d ctrl", i), bus.ctrl, vt[i].exp_ctrl);
            check($sformatf("v%0d aux", i), bus.aux, vt[i].exp_aux);
            if (!vt[i].wr) begin
                check($sformatf("v%0d rdata", i), rd, vt[i].exp_rd);
                check($sformatf("v%0d db idle", i), dut.db_oe, 1'b0);
            end
            if (!vt[i].is_ds) begin
                check($sformatf("v%0d no pulse", i), (we_cnt - we0) + (re_cnt - re0), 0);
            end else if (vt[i].wr) begin
                check($sformatf("v%0d we count", i), we_cnt - we0, 1);
                check($sformatf("v%0d we addr", i), we_addr, vt[i].exp_we);
                check($sformatf("v%0d dbo", i), we_data, vt[i].wdata);
            end else begin
                check($sformatf("v%0d re count", i), re_cnt - re0, 1);
                check($sformatf("v%0d re no we", i), we_cnt - we0, 0);
            end
        end

        // as and ds rise together: write only, pointer untouched, sel cleared.
        access(1'b0, 1'b1, 8'h40, rd);
        check("coll pre da", bus.da, 20'h00040 | HI);
        we0 = we_cnt;
        re0 = re_cnt;
        @(posedge clk);
        #2 bus.wr = 1'b1;
        db_drv = 8'h99;
        db_en  = 1'b1;
        bus.as = 1'b1;
        bus.ds = 1'b1;
        repeat (6) @(posedge clk);
        #2 check("coll da held", bus.da, 20'h00040 | HI);
        bus.as = 1'b0;
        bus.ds = 1'b0;
        repeat (4) @(posedge clk);
        #2 db_en = 1'b0;
        check("coll we count", we_cnt - we0, 1);
        check("coll re count", re_cnt - re0, 0);
        check("coll we addr", we_addr, 20'h00040 | HI);
        check("coll dbo", we_data, 8'h99);
        check("coll da inc", bus.da, 20'h00041 | HI);
        access(1'b0, 1'b1, 8'h66, rd);
        check("coll sel slot1", bus.da, 20'h06641);

        // as fall in the same sample as ds rise: the sel clear wins.
        we0 = we_cnt;
        @(posedge clk);
        #2 bus.wr = 1'b1;
        db_drv = 8'h21;
        db_en  = 1'b1;
        bus.as = 1'b1;
        repeat (4) @(posedge clk);
        #2 check("afr ctrl", bus.ctrl, 2'b10);
        check("afr da", bus.da, 20'h16641);
        bus.as = 1'b0;
        bus.ds = 1'b1;
        repeat (6) @(posedge clk);
        #2 bus.ds = 1'b0;
        repeat (4) @(posedge clk);
        #2 db_en = 1'b0;
        check("afr we count", we_cnt - we0, 1);
        check("afr we addr", we_addr, 20'h16641);
        check("afr da inc", bus.da, 20'h16642);
        access(1'b0, 1'b1, 8'h99, rd);
        check("afr sel slot0", bus.da, 20'h16699);
        check("afr aux kept", bus.aux, 8'h5A);

        // Reset in the middle of an access with both strobes high.
        we0 = we_cnt;
        re0 = re_cnt;
        @(posedge clk);
        #2 bus.wr = 1'b1;
        db_drv = 8'h77;
        db_en  = 1'b1;
        bus.as = 1'b1;
        bus.ds = 1'b1;
        reset  = 1'b0;
        repeat (3) @(posedge clk);
        #2 check("abort da", bus.da, 20'h0);
        check("abort aux", bus.aux, 8'h00);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #2 bus.as = 1'b0;
        bus.ds = 1'b0;
        repeat (4) @(posedge clk);
        #2 db_en = 1'b0;
        check("abort pulses", (we_cnt - we0) + (re_cnt - re0), 0);
        check("abort da held", bus.da, 20'h0);
        access(1'b0, 1'b1, 8'h12, rd);
        check("abort sel slot0", bus.da, 20'h00012);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
